// File: rtl/sram_config_loader.sv
// sram_config_loader: packs a serial config bitstream LSB-first into words and writes them to sram addresses 0..DEPTH-1
module sram_config_loader #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  bit_in,
    input  logic                  bit_valid,
    output logic                  bit_ready,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic                  we,
    output logic                  busy,
    output logic                  done
);
    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, WRITE, DONE} state_t;

    state_t                state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr;
    logic [CW-1:0]         bitcnt;
    logic [DATA_WIDTH-1:0] shreg, word_nxt;
    logic                  xfer, word_end, last_addr, launch;

    assign xfer      = bit_valid && bit_ready;
    assign word_end  = bitcnt == CW'(DATA_WIDTH - 1);
    assign last_addr = &addr;
    assign launch    = start && (state == IDLE || state == DONE);

    // word as it will look once the current bit lands in its slot
    always_comb begin
        for (int i = 0; i < DATA_WIDTH; i++)
            word_nxt[i] = (bitcnt == CW'(i)) ? bit_in : shreg[i];
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // next state: WRITE always lasts one cycle, the last address ends the pass
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: state_nxt = start ? SHIFT : state;
            SHIFT:      state_nxt = (xfer && word_end) ? WRITE : SHIFT;
            WRITE:      state_nxt = last_addr ? DONE : SHIFT;
            default:    state_nxt = IDLE;
        endcase
    end

    // status outputs decoded straight from state
    always_comb begin
        bit_ready = state == SHIFT;
        busy      = state == SHIFT || state == WRITE;
        done      = state == DONE;
    end

    // bit counter, shift register and word address
    always_ff @(posedge clk) begin
        if (rst) begin
            addr   <= '0;
            bitcnt <= '0;
            shreg  <= '0;
        end else if (launch) begin
            addr   <= '0;
            bitcnt <= '0;
        end else if (xfer) begin
            shreg  <= word_nxt;
            bitcnt <= word_end ? '0 : bitcnt + CW'(1);
        end else if (state == WRITE && !last_addr) begin
            addr <= addr + ADDR_WIDTH'(1);
        end
    end

    // sram write port is registered so we/waddr/wdata line up in the WRITE cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else begin
            we <= xfer && word_end;
            if (xfer && word_end) begin
                waddr <= addr;
                wdata <= word_nxt;
            end
        end
    end
endmodule

// File: tb/tb_sram_config_loader.sv
// tb_sram_config_loader: scoreboard and table checks for the serial sram loader at widths 1 and 4
module tb_sram_config_loader;
    typedef struct { logic [3:0] addr; logic [3:0] data; } wr_t;
    typedef struct { logic s0, s1, s2, s3; logic [3:0] exp; } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0] rst, start, bit_in, bit_valid, bit_ready, we, busy, done;
    logic [3:0] waddr0, waddr1, wdata1;
    logic [0:0] wdata0;

    int   nvec = 0, nerr = 0, cyc = 0;
    wr_t  q0[$], q1[$];
    wr_t  e0, e1;
    logic mem0 [16];
    logic [3:0] mem1 [16];
    vec_t tbl [6];
    logic [3:0] nib;

    sram_config_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(1)) dut_a (
        .clk(clk), .rst(rst[0]), .start(start[0]), .bit_in(bit_in[0]), .bit_valid(bit_valid[0]),
        .bit_ready(bit_ready[0]), .waddr(waddr0), .wdata(wdata0), .we(we[0]), .busy(busy[0]), .done(done[0])
    );

    sram_config_loader #(.ADDR_WIDTH(4), .DATA_WIDTH(4)) dut_b (
        .clk(clk), .rst(rst[1]), .start(start[1]), .bit_in(bit_in[1]), .bit_valid(bit_valid[1]),
        .bit_ready(bit_ready[1]), .waddr(waddr1), .wdata(wdata1), .we(we[1]), .busy(busy[1]), .done(done[1])
    );

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // every write pulse is popped against the scoreboard and mirrored into the sram model
    always @(negedge clk) begin
        if (we[0]) begin
            if (q0.size() == 0) chk("we0_unexpected", we[0], 0);
            else begin
                e0 = q0.pop_front();
                chk("wr0_addr", waddr0, e0.addr);
                chk("wr0_data", wdata0, e0.data);
            end
            chk("wr0_ready_low", bit_ready[0], 0);
            mem0[waddr0] = wdata0[0];
        end
        if (we[1]) begin
            if (q1.size() == 0) chk("we1_unexpected", we[1], 0);
            else begin
                e1 = q1.pop_front();
                chk("wr1_addr", waddr1, e1.addr);
                chk("wr1_data", wdata1, e1.data);
            end
            chk("wr1_ready_low", bit_ready[1], 0);
            mem1[waddr1] = wdata1;
        end
    end

    task automatic push(input int d, input int a, input logic [3:0] v);
        wr_t t;
        t.addr = 4'(a);
        t.data = v;
        if (d == 0) q0.push_back(t);
        else q1.push_back(t);
    endtask

    task automatic send(input int d, input logic b);
        bit_in[d] = b;
        bit_valid[d] = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bit_ready[d]) begin
                @(posedge clk);
                #1;
                return;
            end
        end
        chk("send_timeout", bit_ready[d], 1);
    endtask

    task automatic do_start(input int d);
        start[d] = 1'b1;
        @(posedge clk);
        #1;
        start[d] = 1'b0;
    endtask

    task automatic wait_done(input int d);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (done[d]) return;
        end
        chk("done_timeout", done[d], 1);
    endtask

    task automatic pass_a(input logic inv, input bit gapped, input bit poke);
        int s;
        logic b;
        do_start(0);
        s = cyc;
        chk("start_done_low", done[0], 0);
        chk("start_busy", busy[0], 1);
        chk("start_ready", bit_ready[0], 1);
        for (int i = 0; i < 16; i++) begin
            b = logic'(i % 2 == 0) ^ inv;
            push(0, i, {3'b0, b});
            if (gapped && $urandom_range(1) == 1) begin
                bit_valid[0] = 1'b0;
                repeat ($urandom_range(3, 1)) @(posedge clk);
                #1;
            end
            send(0, b);
            if (poke && i == 5) begin
                bit_valid[0] = 1'b0;
                start[0] = 1'b1;
                repeat (2) @(posedge clk);
                #1;
                start[0] = 1'b0;
                chk("poke_busy", busy[0], 1);
                chk("poke_done", done[0], 0);
            end
        end
        bit_valid[0] = 1'b0;
        wait_done(0);
        if (!gapped && !poke) chk("pass_cycles", cyc - s, 32);
        chk("pass_done", done[0], 1);
        chk("pass_busy", busy[0], 0);
        for (int i = 0; i < 16; i++)
            chk($sformatf("mem0[%0d]", i), mem0[i], logic'(i % 2 == 0) ^ inv);
    endtask

    initial begin
        tbl = '{'{1'b1, 1'b0, 1'b1, 1'b1, 4'b1101}, '{1'b0, 1'b0, 1'b0, 1'b1, 4'b1000},
                '{1'b1, 1'b0, 1'b0, 1'b0, 4'b0001}, '{1'b1, 1'b1, 1'b1, 1'b0, 4'b0111},
                '{1'b0, 1'b1, 1'b1, 1'b0, 4'b0110}, '{1'b1, 1'b1, 1'b1, 1'b1, 4'b1111}};
        rst = 2'b11; start = 2'b00; bit_in = 2'b00; bit_valid = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", bit_ready, 0);
        chk("rst_we", we, 0);
        chk("rst_waddr0", waddr0, 0);
        chk("rst_wdata0", wdata0, 0);
        chk("rst_waddr1", waddr1, 0);
        chk("rst_wdata1", wdata1, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 2'b00;
        bit_valid = 2'b11; bit_in = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_ready", bit_ready, 0);
        chk("idle_busy", busy, 0);
        chk("idle_we", we, 0);
        bit_valid = 2'b00;
        pass_a(1'b0, 1'b0, 1'b0);
        bit_valid[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("done_hold", done[0], 1);
        chk("done_ready", bit_ready[0], 0);
        chk("done_busy", busy[0], 0);
        bit_valid[0] = 1'b0;
        pass_a(1'b0, 1'b1, 1'b0);
        pass_a(1'b1, 1'b1, 1'b1);
        do_start(1);
        for (int i = 0; i < 6; i++) begin
            push(1, i, tbl[i].exp);
            send(1, tbl[i].s0);
            send(1, tbl[i].s1);
            send(1, tbl[i].s2);
            send(1, tbl[i].s3);
            chk("vec_we", we[1], 1);
            chk("vec_waddr", waddr1, i);
            chk("vec_wdata", wdata1, tbl[i].exp);
            chk("vec_ready_low", bit_ready[1], 0);
        end
        bit_valid[1] = 1'b0;
        rst[1] = 1'b1;
        @(posedge clk);
        #1;
        rst[1] = 1'b0;
        do_start(1);
        for (int w = 0; w < 5; w++) begin
            nib = 4'($urandom);
            push(1, w, nib);
            for (int k = 0; k < 4; k++) send(1, nib[k]);
        end
        send(1, 1'b1);
        send(1, 1'b0);
        rst[1] = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_ready", bit_ready[1], 0);
        chk("midrst_we", we[1], 0);
        chk("midrst_waddr", waddr1, 0);
        chk("midrst_wdata", wdata1, 0);
        chk("midrst_busy", busy[1], 0);
        chk("midrst_done", done[1], 0);
        rst[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("postrst_busy", busy[1], 0);
        chk("postrst_ready", bit_ready[1], 0);
        bit_valid[1] = 1'b0;
        do_start(1);
        push(1, 0, 4'b0110);
        send(1, 1'b0);
        send(1, 1'b1);
        send(1, 1'b1);
        send(1, 1'b0);
        chk("reload_we", we[1], 1);
        chk("reload_waddr", waddr1, 0);
        chk("reload_wdata", wdata1, 4'b0110);
        bit_valid[1] = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("q0_drained", q0.size(), 0);
        chk("q1_drained", q1.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
